// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and helpers for the multi-channel divider.
// Holds the CNT_W/DIV_RST defaults and the channel-index width function.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 32;
  localparam int DIV_RST_DEF = 25_000_000;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with a pending divisor applied at wrap.
// Ports: clk, rst_n, en, wr (load strobe), val (divisor),
//   duty_val (only with CLK_DIV_MULTI_PWM_EN), tick, clk_out.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
`ifdef CLK_DIV_MULTI_PWM_EN
  input  logic [CNT_W-1:0] duty_val,
`endif
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // A zero divisor behaves as one.
  localparam logic [CNT_W-1:0] DIV_INIT =
    (DIV_RST < 1) ? ONE : CNT_W'(DIV_RST);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pdiv;
  logic             pend;
  logic [CNT_W-1:0] val_eff;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;

  always_comb begin
    val_eff = (val == '0) ? ONE : val;
    // >= keeps the counter bounded even if div ever shrank under it.
    wrap    = en && (cnt >= div - ONE);
    cnt_nxt = wrap ? '0 : cnt + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      div  <= DIV_INIT;
      pdiv <= DIV_INIT;
      pend <= 1'b0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (en) begin
        cnt <= cnt_nxt;
      end
      // Old pending value lands at this wrap; a write in the
      // same cycle stays pending for the following wrap.
      if (wrap && pend) begin
        div <= pdiv;
      end
      if (wr) begin
        pdiv <= val_eff;
        pend <= 1'b1;
      end else if (wrap) begin
        pend <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_MULTI_PWM_EN
  localparam logic [CNT_W-1:0] DUTY_INIT =
    CNT_W'(DIV_RST / 2);

  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] pduty;
  logic [CNT_W-1:0] duty_nxt;

  always_comb begin
    duty_nxt = (wrap && pend) ? pduty : duty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty    <= DUTY_INIT;
      pduty   <= DUTY_INIT;
      clk_out <= 1'b0;
    end else begin
      duty <= duty_nxt;
      if (wr) begin
        pduty <= duty_val;
      end
      // Registered compare of the values that hold after this edge.
      if (en) begin
        clk_out <= (cnt_nxt < duty_nxt);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out <= 1'b0;
    end else if (wrap) begin
      clk_out <= ~clk_out;
    end
  end
`endif

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent clock dividers with runtime divisor.
// Ports: clk, rst_n, en[NUM_CH], div_wr, div_ch, div_val, div_ack,
//   tick[NUM_CH], clk_out[NUM_CH]; duty_val if CLK_DIV_MULTI_PWM_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      div_wr,
  input  logic [ch_w(NUM_CH)-1:0]   div_ch,
  input  logic [CNT_W-1:0]          div_val,
`ifdef CLK_DIV_MULTI_PWM_EN
  input  logic [CNT_W-1:0]          duty_val,
`endif
  output logic                      div_ack,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         clk_out
);

  logic [NUM_CH-1:0] wr_sel;

  // Out-of-range indices match no channel, so they never ack.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = div_wr && (int'(div_ch) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ack <= 1'b0;
    end else begin
      div_ack <= |wr_sel;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .wr       (wr_sel[g]),
      .val      (div_val),
`ifdef CLK_DIV_MULTI_PWM_EN
      .duty_val (duty_val),
`endif
      .tick     (tick[g]),
      .clk_out  (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed bench for clk_div_multi (default build).
// Three channels, DIV_RST=10; expected values are hand-derived.
module tb_clk_div_multi;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int DIV_RST = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       en = '0;
  logic             div_wr = 1'b0;
  logic [1:0]       div_ch = '0;
  logic [CNT_W-1:0] div_val = '0;
  logic             div_ack;
  logic [2:0]       tick;
  logic [2:0]       clk_out;

  int errors = 0;
  int checks = 0;

  logic t_e;
  logic c_e;
  logic a_e;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .div_ack (div_ack),
    .tick    (tick),
    .clk_out (clk_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [CNT_W-1:0] v);
    div_wr  = 1'b1;
    div_ch  = ch;
    div_val = v;
  endtask

  task automatic restart(input logic [2:0] e);
    rst_n  = 1'b0;
    en     = '0;
    div_wr = 1'b0;
    step;
    step;
    rst_n  = 1'b1;
    en     = e;
  endtask

  initial begin
    // Reset state
    step;
    step;
    chk("rst_tick", 8'(tick), 8'h0);
    chk("rst_clk", 8'(clk_out), 8'h0);
    chk("rst_ack", 8'(div_ack), 8'h0);
    rst_n = 1'b1;
    en    = 3'b111;

    // A: default divisor on all channels
    for (int n = 1; n <= 35; n++) begin
      step;
      t_e = (n % 10 == 0);
      c_e = ((n / 10) % 2 == 1);
      chk("A_tick", 8'(tick), 8'({3{t_e}}));
      chk("A_clk", 8'(clk_out), 8'({3{c_e}}));
    end

    // Asynchronous reset mid-period with clk_out high
    rst_n = 1'b0;
    #2;
    chk("arst_tick", 8'(tick), 8'h0);
    chk("arst_clk", 8'(clk_out), 8'h0);
    chk("arst_ack", 8'(div_ack), 8'h0);
    en = '0;
    step;
    rst_n = 1'b1;
    en    = 3'b001;

    // B: write 4 at cnt=3, applied at the wrap
    for (int n = 1; n <= 22; n++) begin
      step;
      t_e = (n == 10) || (n > 10 && (n - 10) % 4 == 0);
      c_e = (n >= 10) && (((n - 10) / 4) % 2 == 0);
      a_e = (n == 4);
      chk("B_tick", 8'(tick), 8'({2'b00, t_e}));
      chk("B_clk", 8'(clk_out), 8'({2'b00, c_e}));
      chk("B_ack", 8'(div_ack), 8'(a_e));
      if (n == 3) wr(2'd0, 16'd4);
      if (n == 4) div_wr = 1'b0;
    end

    // C: 7 then 5 -> only 5; channel 3 ignored
    restart(3'b001);
    for (int n = 1; n <= 26; n++) begin
      step;
      t_e = (n == 10) || (n > 10 && (n - 10) % 5 == 0);
      c_e = (n >= 10) && (((n - 10) / 5) % 2 == 0);
      a_e = (n == 3) || (n == 6);
      chk("C_tick", 8'(tick), 8'({2'b00, t_e}));
      chk("C_clk", 8'(clk_out), 8'({2'b00, c_e}));
      chk("C_ack", 8'(div_ack), 8'(a_e));
      if (n == 2) wr(2'd0, 16'd7);
      if (n == 3) div_wr = 1'b0;
      if (n == 5) wr(2'd0, 16'd5);
      if (n == 6) div_wr = 1'b0;
      if (n == 7) wr(2'd3, 16'd3);
      if (n == 8) div_wr = 1'b0;
    end

    // D: write coinciding with the wrap stays pending
    restart(3'b001);
    for (int n = 1; n <= 27; n++) begin
      step;
      t_e = (n == 10) || (n == 14) || (n == 20) || (n == 26);
      c_e = (n >= 10 && n < 14) || (n >= 20 && n < 26);
      a_e = (n == 3) || (n == 10);
      chk("D_tick", 8'(tick), 8'({2'b00, t_e}));
      chk("D_clk", 8'(clk_out), 8'({2'b00, c_e}));
      chk("D_ack", 8'(div_ack), 8'(a_e));
      if (n == 2) wr(2'd0, 16'd4);
      if (n == 3) div_wr = 1'b0;
      if (n == 9) wr(2'd0, 16'd6);
      if (n == 10) div_wr = 1'b0;
    end

    // E: divisor 0 behaves as 1
    restart(3'b001);
    for (int n = 1; n <= 16; n++) begin
      step;
      t_e = (n >= 10);
      c_e = (n >= 10) && ((n - 10) % 2 == 0);
      a_e = (n == 2);
      chk("E_tick", 8'(tick), 8'({2'b00, t_e}));
      chk("E_clk", 8'(clk_out), 8'({2'b00, c_e}));
      chk("E_ack", 8'(div_ack), 8'(a_e));
      if (n == 1) wr(2'd0, 16'd0);
      if (n == 2) div_wr = 1'b0;
    end

    // F: en low 13 cycles with a pending divisor of 3
    restart(3'b001);
    for (int n = 1; n <= 40; n++) begin
      step;
      t_e = (n == 10) || (n == 33) || (n == 36) || (n == 39);
      c_e = (n >= 10 && n < 33) || (n >= 36 && n < 39);
      a_e = (n == 14);
      chk("F_tick", 8'(tick), 8'({2'b00, t_e}));
      chk("F_clk", 8'(clk_out), 8'({2'b00, c_e}));
      chk("F_ack", 8'(div_ack), 8'(a_e));
      if (n == 13) wr(2'd0, 16'd3);
      if (n == 14) begin
        div_wr = 1'b0;
        en     = 3'b000;
      end
      if (n == 27) en = 3'b001;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Parameters
REQ-001 NUM_CH, default 2, number of independent divider channels (1..8).
REQ-002 CNT_W, default 32, counter and divisor width in bits.
REQ-003 DIV_RST, default 25_000_000, divisor loaded into every channel at reset.

Interface
REQ-004 clk  in  1  single system clock; all logic on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  NUM_CH  per-channel run enable.
REQ-007 div_wr  in  1  divisor write strobe, one cycle.
REQ-008 div_ch  in  $clog2(NUM_CH) (min 1)  target channel of the write.
REQ-009 div_val  in  CNT_W  new divisor value.
REQ-010 div_ack  out  1  one-cycle pulse when a write is accepted.
REQ-011 tick  out  NUM_CH  one-cycle enable pulse per channel period.
REQ-012 clk_out  out  NUM_CH  divided square wave per channel, registered.

Function
REQ-013 Each channel SHALL hold counter cnt, active divisor div, pending divisor pdiv and flag pend.
REQ-014 When en[i]=1, cnt SHALL count 0..div-1 and wrap to 0; tick[i]=1 in the cycle after cnt==div-1 is registered, i.e. exactly one tick every div cycles.
REQ-015 When en[i]=0, cnt, clk_out[i] and div SHALL hold and tick[i] SHALL be 0; on re-enable counting resumes from the held cnt.
REQ-016 clk_out[i] SHALL toggle at each wrap: period 2*div cycles, 50% duty.
REQ-017 div_val 0 SHALL be treated as 1: tick every cycle, clk_out = clk/2.
REQ-018 A div_wr with div_ch < NUM_CH SHALL load pdiv, set pend, and pulse div_ack in the next cycle.
REQ-019 A div_wr with div_ch >= NUM_CH SHALL be ignored with no div_ack.
REQ-020 pdiv SHALL be transferred to div only at the wrap (cnt==div-1 -> 0), clearing pend; no truncated or glitched period.
REQ-021 If a write arrives while pend is set, pdiv SHALL be overwritten; only the latest value is applied.
REQ-022 If a write coincides with the wrap cycle, the old pdiv (if pending) SHALL be applied at this wrap and the new value SHALL remain pending for the next wrap.
REQ-023 If en[i]=0 while pend is set, the pending value SHALL apply at the first wrap after re-enable.
REQ-024 Channels SHALL be fully independent; simultaneous wraps on several channels are allowed.

Reset
REQ-025 On rst_n low: cnt=0, div=pdiv=DIV_RST, pend=0, tick=0, clk_out=0, div_ack=0, effective immediately, including mid-period or with a write pending.
REQ-026 The first tick after reset release SHALL occur DIV_RST cycles after the first enabled clock edge.

Configuration
REQ-027 Macro CLK_DIV_MULTI_PWM_EN, when defined, SHALL add input duty_val (CNT_W), written with div_val into a pending duty register and applied at the same wrap.
REQ-028 With CLK_DIV_MULTI_PWM_EN defined, clk_out[i] SHALL equal (cnt < duty): period div, duty/div high; duty>=div gives constant 1 and duty=0 gives constant 0; reset duty = DIV_RST/2.
REQ-029 Without CLK_DIV_MULTI_PWM_EN, there SHALL be no duty_val port and REQ-016 applies; tick behaviour SHALL be identical in both builds.

Structure
REQ-030 Package clk_div_pkg SHALL hold CNT_W and DIV_RST defaults and the channel-index width function.
REQ-031 Per-channel logic SHALL be sub-module clk_div_ch, generated NUM_CH times; the top holds only the write decode and div_ack.

Verification
REQ-032 Reset release, en=1, DIV_RST=10 -> tick every 10 cycles; clk_out period 20 cycles, first tick 10 cycles after release.
REQ-033 div=10, write 4 at cnt=3 -> div_ack next cycle; remaining period stays 10, then ticks every 4.
REQ-034 Write 7 then write 5 before the wrap -> only 5 applied; write to channel NUM_CH -> no ack, no change.
REQ-035 Write div_val=0 -> tick high every cycle, clk_out toggles every cycle.
REQ-036 en low for 13 cycles mid-period -> no ticks, clk_out held, period resumes with the same phase; rst_n pulse mid-period -> all outputs 0 asynchronously.
REQ-037 PWM build: div=8, duty=3 -> clk_out high 3 cycles and low 5 cycles; duty=9 -> constant 1.
